tri_setup: RTL and testbench

TRI_SETUP -- requirements
Module: tri_setup

---
 rtl/tri_setup.sv | 200 ++++++++++++++++++++
 tb/tb_tri_setup.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_setup.sv
// Triangle setup: captures three vertices, derives edge equations, twice-area,
// bounding box and cull flag using one shared signed multiplier.
module tri_setup #(
   parameter int CULL_BACKFACE = 1
) (
   input  logic        clk_pix,
   input  logic        rst,
   input  logic        start,
   input  logic [9:0]  ax,
   input  logic [9:0]  ay,
   input  logic [9:0]  bx,
   input  logic [9:0]  by,
   input  logic [9:0]  cx,
   input  logic [9:0]  cy,
   output logic        busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [10:0] e0_a,
   output logic [10:0] e1_a,
   output logic [10:0] e2_a,
   output logic [10:0] e0_b,
   output logic [10:0] e1_b,
   output logic [10:0] e2_b,
   output logic [20:0] e0_c,
   output logic [20:0] e1_c,
   output logic [20:0] e2_c,
   output logic [21:0] area2,
   output logic [9:0]  min_x,
   output logic [9:0]  max_x,
   output logic [9:0]  min_y,
   output logic [9:0]  max_y,
   output logic        culled
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN, S_DONE} state_t;

   state_t            r_state, w_next;
   logic              w_capture;
   logic [9:0]        r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
   logic [2:0]        r_step, r_pidx;
   logic              r_last, r_pv;
   logic [21:0]       r_prod;
   logic [7:0][21:0]  r_p;
   logic              r_out_valid, r_culled;
   logic [10:0]       r_e0_a, r_e1_a, r_e2_a, r_e0_b, r_e1_b, r_e2_b;
   logic [20:0]       r_e0_c, r_e1_c, r_e2_c;
   logic [21:0]       r_area2;
   logic [9:0]        r_min_x, r_max_x, r_min_y, r_max_y;

   logic signed [10:0] w_sax, w_say, w_sbx, w_sby, w_scx, w_scy;
   logic signed [10:0] w_opa, w_opb;
   logic signed [21:0] w_prod, w_area;
   logic signed [20:0] w_c0, w_c1, w_c2;
   logic [9:0]         w_min_x, w_max_x, w_min_y, w_max_y;
   logic               w_culled;

   always_ff @(posedge clk_pix) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE: if (start) begin
            w_capture = 1'b1;
            w_next    = S_MUL;
         end
         // The multiplier output is registered, so MUL leaves only after the
         // eighth product has been retired into r_p.
         S_MUL:  if (r_last) w_next = S_FIN;
         S_FIN:  w_next = S_DONE;
         S_DONE: if (r_out_valid && out_ready) begin
            w_capture = start;
            w_next    = start ? S_MUL : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_sax = {1'b0, r_ax};
   assign w_say = {1'b0, r_ay};
   assign w_sbx = {1'b0, r_bx};
   assign w_sby = {1'b0, r_by};
   assign w_scx = {1'b0, r_cx};
   assign w_scy = {1'b0, r_cy};

   // Steps 0..5: cross terms of the three edge constants; 6..7: area terms.
   always_comb begin
      w_opa = '0;
      w_opb = '0;
      case (r_step)
         3'd0: begin w_opa = w_sax;         w_opb = w_sby;         end
         3'd1: begin w_opa = w_sbx;         w_opb = w_say;         end
         3'd2: begin w_opa = w_sbx;         w_opb = w_scy;         end
         3'd3: begin w_opa = w_scx;         w_opb = w_sby;         end
         3'd4: begin w_opa = w_scx;         w_opb = w_say;         end
         3'd5: begin w_opa = w_sax;         w_opb = w_scy;         end
         3'd6: begin w_opa = w_sbx - w_sax; w_opb = w_scy - w_say; end
         3'd7: begin w_opa = w_scx - w_sax; w_opb = w_sby - w_say; end
         default: ;
      endcase
   end

   assign w_prod = 22'(w_opa) * 22'(w_opb);
   assign w_c0   = 21'($signed(r_p[0]) - $signed(r_p[1]));
   assign w_c1   = 21'($signed(r_p[2]) - $signed(r_p[3]));
   assign w_c2   = 21'($signed(r_p[4]) - $signed(r_p[5]));
   assign w_area = $signed(r_p[6]) - $signed(r_p[7]);
   assign w_culled = (CULL_BACKFACE != 0) ? (w_area <= 22'sd0) : (w_area == 22'sd0);

   always_comb begin
      w_min_x = r_ax;
      w_max_x = r_ax;
      w_min_y = r_ay;
      w_max_y = r_ay;
      if (r_bx < w_min_x) w_min_x = r_bx;
      if (r_cx < w_min_x) w_min_x = r_cx;
      if (r_bx > w_max_x) w_max_x = r_bx;
      if (r_cx > w_max_x) w_max_x = r_cx;
      if (r_by < w_min_y) w_min_y = r_by;
      if (r_cy < w_min_y) w_min_y = r_cy;
      if (r_by > w_max_y) w_max_y = r_by;
      if (r_cy > w_max_y) w_max_y = r_cy;
   end

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         {r_ax, r_ay, r_bx, r_by, r_cx, r_cy} <= '0;
         r_step      <= '0;
         r_pidx      <= '0;
         r_last      <= 1'b0;
         r_pv        <= 1'b0;
         r_prod      <= '0;
         r_p         <= '0;
         r_out_valid <= 1'b0;
         r_culled    <= 1'b0;
         {r_e0_a, r_e1_a, r_e2_a, r_e0_b, r_e1_b, r_e2_b} <= '0;
         {r_e0_c, r_e1_c, r_e2_c} <= '0;
         r_area2     <= '0;
         {r_min_x, r_max_x, r_min_y, r_max_y} <= '0;
      end else begin
         if (w_capture) begin
            {r_ax, r_ay, r_bx, r_by, r_cx, r_cy} <= {ax, ay, bx, by, cx, cy};
            r_step <= '0;
            r_last <= 1'b0;
            r_pv   <= 1'b0;
         end else if (r_state == S_MUL && !r_last) begin
            r_prod <= w_prod;
            r_pidx <= r_step;
            r_pv   <= 1'b1;
            if (r_step == 3'd7) r_last <= 1'b1;
            else                r_step <= r_step + 3'd1;
         end else begin
            r_pv <= 1'b0;
         end
         if (r_pv) r_p[r_pidx] <= r_prod;
         if (r_state == S_FIN) begin
            r_e0_a      <= w_say - w_sby;
            r_e0_b      <= w_sbx - w_sax;
            r_e1_a      <= w_sby - w_scy;
            r_e1_b      <= w_scx - w_sbx;
            r_e2_a      <= w_scy - w_say;
            r_e2_b      <= w_sax - w_scx;
            r_e0_c      <= w_c0;
            r_e1_c      <= w_c1;
            r_e2_c      <= w_c2;
            r_area2     <= w_area;
            r_min_x     <= w_min_x;
            r_max_x     <= w_max_x;
            r_min_y     <= w_min_y;
            r_max_y     <= w_max_y;
            r_culled    <= w_culled;
            r_out_valid <= 1'b1;
         end else if (r_state == S_DONE && r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_out_valid;
   assign e0_a      = r_e0_a;
   assign e1_a      = r_e1_a;
   assign e2_a      = r_e2_a;
   assign e0_b      = r_e0_b;
   assign e1_b      = r_e1_b;
   assign e2_b      = r_e2_b;
   assign e0_c      = r_e0_c;
   assign e1_c      = r_e1_c;
   assign e2_c      = r_e2_c;
   assign area2     = r_area2;
   assign min_x     = r_min_x;
   assign max_x     = r_max_x;
   assign min_y     = r_min_y;
   assign max_y     = r_max_y;
   assign culled    = r_culled;

endmodule

// File: tb/tb_tri_setup.sv
// Randomized bench for tri_setup: two instances (backface cull on/off)
// checked against an arithmetic model of the edge/area/bbox rules.
module tb_tri_setup;

   logic clk_pix = 1'b0;
   always #5 clk_pix = ~clk_pix;

   logic       rst, start, out_ready;
   logic [9:0] ax, ay, bx, by, cx, cy;

   logic        busy, out_valid, culled;
   logic [10:0] e0_a, e1_a, e2_a, e0_b, e1_b, e2_b;
   logic [20:0] e0_c, e1_c, e2_c;
   logic [21:0] area2;
   logic [9:0]  min_x, max_x, min_y, max_y;

   logic        z_busy, z_out_valid, z_culled;
   logic [10:0] z_e0_a, z_e1_a, z_e2_a, z_e0_b, z_e1_b, z_e2_b;
   logic [20:0] z_e0_c, z_e1_c, z_e2_c;
   logic [21:0] z_area2;
   logic [9:0]  z_min_x, z_max_x, z_min_y, z_max_y;

   tri_setup #(.CULL_BACKFACE(1)) dut (
      .clk_pix(clk_pix), .rst(rst), .start(start),
      .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .e0_a(e0_a), .e1_a(e1_a), .e2_a(e2_a), .e0_b(e0_b), .e1_b(e1_b), .e2_b(e2_b),
      .e0_c(e0_c), .e1_c(e1_c), .e2_c(e2_c), .area2(area2),
      .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y), .culled(culled));

   tri_setup #(.CULL_BACKFACE(0)) dut_nc (
      .clk_pix(clk_pix), .rst(rst), .start(start),
      .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
      .busy(z_busy), .out_valid(z_out_valid), .out_ready(out_ready),
      .e0_a(z_e0_a), .e1_a(z_e1_a), .e2_a(z_e2_a), .e0_b(z_e0_b), .e1_b(z_e1_b), .e2_b(z_e2_b),
      .e0_c(z_e0_c), .e1_c(z_e1_c), .e2_c(z_e2_c), .area2(z_area2),
      .min_x(z_min_x), .max_x(z_max_x), .min_y(z_min_y), .max_y(z_max_y), .culled(z_culled));

   int n_chk = 0;
   int n_pass = 0;

   // expected result of the last captured triangle
   int m_ea[3], m_eb[3], m_ec[3];
   int m_area, m_minx, m_maxx, m_miny, m_maxy, m_cull1, m_cull0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic set_v(input int a_x, a_y, b_x, b_y, c_x, c_y);
      int vx[3], vy[3];
      ax = 10'(a_x); ay = 10'(a_y); bx = 10'(b_x);
      by = 10'(b_y); cx = 10'(c_x); cy = 10'(c_y);
      vx = '{a_x, b_x, c_x};
      vy = '{a_y, b_y, c_y};
      for (int k = 0; k < 3; k++) begin
         m_ea[k] = vy[k] - vy[(k+1)%3];
         m_eb[k] = vx[(k+1)%3] - vx[k];
         m_ec[k] = vx[k] * vy[(k+1)%3] - vx[(k+1)%3] * vy[k];
      end
      m_area = (b_x - a_x) * (c_y - a_y) - (c_x - a_x) * (b_y - a_y);
      m_minx = vx[0]; m_maxx = vx[0]; m_miny = vy[0]; m_maxy = vy[0];
      for (int k = 1; k < 3; k++) begin
         if (vx[k] < m_minx) m_minx = vx[k];
         if (vx[k] > m_maxx) m_maxx = vx[k];
         if (vy[k] < m_miny) m_miny = vy[k];
         if (vy[k] > m_maxy) m_maxy = vy[k];
      end
      m_cull1 = (m_area <= 0) ? 1 : 0;
      m_cull0 = (m_area == 0) ? 1 : 0;
   endtask

   task automatic check_out(input string tag);
      chk({tag, ".e0a"}, $signed(e0_a), m_ea[0]);
      chk({tag, ".e1a"}, $signed(e1_a), m_ea[1]);
      chk({tag, ".e2a"}, $signed(e2_a), m_ea[2]);
      chk({tag, ".e0b"}, $signed(e0_b), m_eb[0]);
      chk({tag, ".e1b"}, $signed(e1_b), m_eb[1]);
      chk({tag, ".e2b"}, $signed(e2_b), m_eb[2]);
      chk({tag, ".e0c"}, $signed(e0_c), m_ec[0]);
      chk({tag, ".e1c"}, $signed(e1_c), m_ec[1]);
      chk({tag, ".e2c"}, $signed(e2_c), m_ec[2]);
      chk({tag, ".area"}, $signed(area2), m_area);
      chk({tag, ".minx"}, min_x, m_minx);
      chk({tag, ".maxx"}, max_x, m_maxx);
      chk({tag, ".miny"}, min_y, m_miny);
      chk({tag, ".maxy"}, max_y, m_maxy);
      chk({tag, ".cull1"}, culled, m_cull1);
      chk({tag, ".cull0"}, z_culled, m_cull0);
      chk({tag, ".nc_area"}, $signed(z_area2), m_area);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".ov"}, out_valid, 0);
      chk({tag, ".cull"}, culled, 0);
      chk({tag, ".area"}, area2, 0);
      chk({tag, ".e0a"}, e0_a, 0);
      chk({tag, ".e2c"}, e2_c, 0);
      chk({tag, ".maxx"}, max_x, 0);
      chk({tag, ".maxy"}, max_y, 0);
   endtask

   task automatic fire();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // counts edges from the capture edge until out_valid; optionally churns inputs
   task automatic wait_result(input string tag, input bit junk);
      int n = 0;
      do begin
         if (junk) begin
            ax = 10'($urandom); ay = 10'($urandom); bx = 10'($urandom);
            by = 10'($urandom); cx = 10'($urandom); cy = 10'($urandom);
            start = 1'($urandom);
         end
         tick();
         n++;
         if (!out_valid && n < 10) chk({tag, ".busy"}, busy, 1);
      end while (!out_valid && n < 40);
      start = 1'b0;
      chk({tag, ".lat"}, n, 10);
      check_out(tag);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, ".hs_ov"}, out_valid, 0);
      chk({tag, ".hs_busy"}, busy, 0);
   endtask

   initial begin
      int old_area, ovcnt, waitc;
      rst = 1'b1; start = 1'b1; out_ready = 1'b1;
      set_v(0, 0, 0, 0, 0, 0);
      tick(); tick(); tick();
      check_zero("reset");
      rst = 1'b0; start = 1'b0;
      tick(); tick();
      chk("idle_rdy.ov", out_valid, 0);
      chk("idle_rdy.busy", busy, 0);
      out_ready = 1'b0;

      set_v(320, 120, 420, 240, 220, 240);
      fire();
      wait_result("r29", 1'b0);
      chk("r29.area_k", $signed(area2), 24000);
      chk("r29.e2c_k", $signed(e2_c), -50400);
      handshake("r29");

      set_v(320, 120, 220, 240, 420, 240);
      fire();
      wait_result("r30", 1'b0);
      chk("r30.area_k", $signed(area2), -24000);
      handshake("r30");

      set_v(100, 100, 100, 100, 100, 100);
      fire();
      wait_result("r31", 1'b0);
      chk("r31.cull_nc_k", z_culled, 1);
      handshake("r31");

      // stall with junk inputs and start toggling
      set_v(320, 120, 420, 240, 220, 240);
      fire();
      wait_result("r32", 1'b1);
      for (int i = 0; i < 20; i++) begin
         ax = 10'($urandom); by = 10'($urandom); cy = 10'($urandom);
         start = 1'($urandom);
         tick();
         chk("r32.ov", out_valid, 1);
         chk("r32.busy", busy, 1);
         chk("r32.area", $signed(area2), m_area);
         chk("r32.e1c", $signed(e1_c), m_ec[1]);
      end
      start = 1'b0;
      check_out("r32h");
      handshake("r32");

      // new start accepted on the handshake edge
      set_v(320, 120, 420, 240, 220, 240);
      fire();
      wait_result("r33a", 1'b0);
      old_area = m_area;
      set_v(0, 0, 639, 0, 0, 479);
      out_ready = 1'b1;
      fire();
      out_ready = 1'b0;
      chk("r33.ov_clr", out_valid, 0);
      chk("r33.busy", busy, 1);
      chk("r33.hold", $signed(area2), old_area);
      wait_result("r33", 1'b0);
      chk("r33.area_k", $signed(area2), 306081);
      handshake("r33");

      // reset mid-MUL
      set_v(320, 120, 420, 240, 220, 240);
      fire();
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("r34rst");
      ovcnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid) ovcnt++;
      end
      chk("r34.no_ov", ovcnt, 0);
      fire();
      wait_result("r34", 1'b0);
      // reset while holding a result
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("rst_done");

      for (int i = 0; i < 25; i++) begin
         if (i % 6 == 0)
            set_v($urandom_range(0, 1023), $urandom_range(0, 1023), 5, 5, 5, 5);
         else
            set_v($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
         fire();
         wait_result($sformatf("rnd%0d", i), 1'b1);
         waitc = $urandom_range(0, 3);
         for (int j = 0; j < waitc; j++) begin
            tick();
            chk("rnd.hold", $signed(area2), m_area);
         end
         handshake("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
